// File: rtl/wb_stage.sv
// wb_stage -- RV32I writeback stage.
//
// Merges single-cycle ALU results and in-order load returns onto the
// register file's single write port. An in-order pending-load queue holds
// each issued load's destination until its data has been written back, and
// a per-register busy vector is exported so decode can stall on load-use
// and WAW hazards.
//
// Ports:
//   clk, resetn                  core clock, async active-low reset
//   alu_valid/alu_rd/alu_data    ALU result (fixed priority on the write port)
//   ld_issue/ld_issue_rd         load issued to memory (accepted when ready)
//   ld_issue_ready               queue has a free entry
//   ld_rsp_valid/ld_rsp_data     load data return, in issue order
//   reg_write/rd/write_data      register file write port (registered)
//   busy                         per-register pending-load mask, bit 0 = 0
//   rsp_err                      sticky: response with nothing outstanding
module wb_stage #(
   parameter int LQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        ld_issue,
   input  logic [4:0]  ld_issue_rd,
   output logic        ld_issue_ready,
   input  logic        ld_rsp_valid,
   input  logic [31:0] ld_rsp_data,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [31:0] write_data,
   output logic [31:0] busy,
   output logic        rsp_err
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
   localparam logic [PW:0] DEPTH_P = (PW+1)'(LQ_DEPTH);

   // Queue storage
   logic [LQ_DEPTH-1:0]            ent_vld_q, ent_vld_d;
   logic [LQ_DEPTH-1:0]            ent_done_q, ent_done_d;
   logic [LQ_DEPTH-1:0][4:0]       ent_rd_q, ent_rd_d;
   logic [LQ_DEPTH-1:0][31:0]      ent_data_q, ent_data_d;

   // Pointers carry one extra wrap bit so that a full queue with every
   // entry unreturned (rptr index == tail index) is still distinguishable
   // from "nothing unreturned".
   logic [PW:0] tail_q, tail_d, rptr_q, rptr_d, head_q, head_d;

   logic        wr_en_q, wr_en_d;
   logic [4:0]  wr_rd_q, wr_rd_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        rsp_err_q, rsp_err_d;

   logic [PW:0]   count;
   logic [PW-1:0] tail_idx, rptr_idx, head_idx;
   logic          issue_fire, rsp_ok, head_rdy;
   logic [31:0]   busy_vec;

   assign count          = tail_q - head_q;
   assign tail_idx       = tail_q[PW-1:0];
   assign rptr_idx       = rptr_q[PW-1:0];
   assign head_idx       = head_q[PW-1:0];
   assign ld_issue_ready = (count < DEPTH_P);
   assign issue_fire     = ld_issue && ld_issue_ready;
   assign rsp_ok         = (rptr_q != tail_q);
   assign head_rdy       = ent_vld_q[head_idx] && ent_done_q[head_idx];

   always_comb begin
      ent_vld_d  = ent_vld_q;
      ent_done_d = ent_done_q;
      ent_rd_d   = ent_rd_q;
      ent_data_d = ent_data_q;
      tail_d     = tail_q;
      rptr_d     = rptr_q;
      head_d     = head_q;
      wr_en_d    = 1'b0;
      wr_rd_d    = wr_rd_q;
      wr_data_d  = wr_data_q;
      rsp_err_d  = rsp_err_q;

      // Write port: ALU wins; a completed head load waits behind it.
      if (alu_valid) begin
         wr_en_d   = (alu_rd != 5'd0);
         wr_rd_d   = alu_rd;
         wr_data_d = alu_data;
      end else if (head_rdy) begin
         wr_en_d             = (ent_rd_q[head_idx] != 5'd0);
         wr_rd_d             = ent_rd_q[head_idx];
         wr_data_d           = ent_data_q[head_idx];
         ent_vld_d[head_idx] = 1'b0;
         head_d              = head_q + PTR_ONE;
      end

      // Response fills the oldest unreturned entry. The retiring entry (if
      // any) is already done, so it never aliases rptr.
      if (ld_rsp_valid) begin
         if (rsp_ok) begin
            ent_data_d[rptr_idx] = ld_rsp_data;
            ent_done_d[rptr_idx] = 1'b1;
            rptr_d               = rptr_q + PTR_ONE;
         end else begin
            rsp_err_d = 1'b1;
         end
      end

      // Issue is gated by the registered count, so tail never lands on the
      // head entry that may be retiring this cycle.
      if (issue_fire) begin
         ent_vld_d[tail_idx]  = 1'b1;
         ent_done_d[tail_idx] = 1'b0;
         ent_rd_d[tail_idx]   = ld_issue_rd;
         tail_d               = tail_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ent_vld_q  <= '0;
         ent_done_q <= '0;
         ent_rd_q   <= '0;
         ent_data_q <= '0;
         tail_q     <= '0;
         rptr_q     <= '0;
         head_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_rd_q    <= 5'd0;
         wr_data_q  <= 32'd0;
         rsp_err_q  <= 1'b0;
      end else begin
         ent_vld_q  <= ent_vld_d;
         ent_done_q <= ent_done_d;
         ent_rd_q   <= ent_rd_d;
         ent_data_q <= ent_data_d;
         tail_q     <= tail_d;
         rptr_q     <= rptr_d;
         head_q     <= head_d;
         wr_en_q    <= wr_en_d;
         wr_rd_q    <= wr_rd_d;
         wr_data_q  <= wr_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Busy mask from registered queue state; x0 never stalls decode.
   always_comb begin
      busy_vec = 32'd0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (ent_vld_q[i]) busy_vec[ent_rd_q[i]] = 1'b1;
      end
   end

   assign busy       = {busy_vec[31:1], 1'b0};
   assign reg_write  = wr_en_q;
   assign rd         = wr_rd_q;
   assign write_data = wr_data_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   localparam int DEPTH = 4;

   logic        clk, resetn;
   logic        alu_valid, ld_issue, ld_rsp_valid;
   logic [4:0]  alu_rd, ld_issue_rd;
   logic [31:0] alu_data, ld_rsp_data;
   logic        ld_issue_ready, reg_write, rsp_err;
   logic [4:0]  rd;
   logic [31:0] write_data, busy;

   wb_stage #(.LQ_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
      .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
      .reg_write(reg_write), .rd(rd), .write_data(write_data),
      .busy(busy), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: pending destinations and returned data, both in
   // program order; the head load may write once its data has come back.
   int unsigned m_rd[$];
   logic [31:0] m_dat[$];
   logic        m_we;
   logic [4:0]  m_wrd;
   logic [31:0] m_wd;
   logic        m_err;

   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] adat;
      logic li; logic [4:0] lrd;
      logic rv; logic [31:0] rdat;
      logic e_we; logic [4:0] e_rd; logic [31:0] e_wd;
      logic [31:0] e_busy; logic e_rdy; logic e_err;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                               logic li, logic [4:0] lrd, logic rv, logic [31:0] rdat,
                               logic e_we, logic [4:0] e_rd, logic [31:0] e_wd,
                               logic [31:0] e_busy, logic e_rdy, logic e_err);
      vec_t v;
      v.av = av; v.ard = ard; v.adat = adat; v.li = li; v.lrd = lrd;
      v.rv = rv; v.rdat = rdat; v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd;
      v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_busy();
      logic [31:0] b = 32'd0;
      foreach (m_rd[i]) if (m_rd[i] != 0) b[m_rd[i]] = 1'b1;
      return b;
   endfunction

   task automatic model_reset();
      m_rd.delete(); m_dat.delete();
      m_we = 1'b0; m_wrd = 5'd0; m_wd = 32'd0; m_err = 1'b0;
   endtask

   task automatic model_cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                              input logic li, input logic [4:0] lrd,
                              input logic rv, input logic [31:0] rdat);
      bit ready  = (m_rd.size() < DEPTH);
      bit rsp_ok = (m_dat.size() < m_rd.size());
      if (av) begin
         m_we = (ard != 0); m_wrd = ard; m_wd = adat;
      end else if (m_dat.size() > 0) begin
         m_we = (m_rd[0] != 0); m_wrd = 5'(m_rd[0]); m_wd = m_dat[0];
         void'(m_rd.pop_front()); void'(m_dat.pop_front());
      end else begin
         m_we = 1'b0;
      end
      if (rv) begin
         if (rsp_ok) m_dat.push_back(rdat);
         else m_err = 1'b1;
      end
      if (li && ready) m_rd.push_back(lrd);
   endtask

   // One clock: drive, advance model, sample 1 time unit after the edge.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic li, input logic [4:0] lrd,
                       input logic rv, input logic [31:0] rdat);
      logic rdy_before;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      ld_issue = li; ld_issue_rd = lrd; ld_rsp_valid = rv; ld_rsp_data = rdat;
      rdy_before = (m_rd.size() < DEPTH);
      chk("ready_pre", {31'd0, ld_issue_ready}, {31'd0, rdy_before});
      model_cycle(av, ard, adat, li, lrd, rv, rdat);
      @(posedge clk);
      #1;
      chk("m_reg_write", {31'd0, reg_write}, {31'd0, m_we});
      if (m_we) begin
         chk("m_rd", {27'd0, rd}, {27'd0, m_wrd});
         chk("m_write_data", write_data, m_wd);
      end
      chk("m_busy", busy, m_busy());
      chk("m_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
   endtask

   task automatic chk_reset_vals();
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_rd", {27'd0, rd}, 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_ready", {31'd0, ld_issue_ready}, 32'd1);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
   endtask

   initial begin
      resetn = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_issue = 0; ld_issue_rd = 0; ld_rsp_valid = 0; ld_rsp_data = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals();
      resetn = 1'b1;

      //        av ard  adat          li lrd rv rdat          we rd  wd            busy       rdy err
      tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,         1, 5, 32'hDEADBEEF, 32'h0,     1, 0));
      tbl.push_back(mk(1, 0, 32'h11111111, 0, 0, 0, 0,         0, 0, 32'h11111111, 32'h0,     1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         0, 0, 32'h11111111, 32'h0,     1, 0));
      // single load rd=7
      tbl.push_back(mk(0, 0, 0,            1, 7, 0, 0,         0, 0, 32'h11111111, 32'h80,    1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         0, 0, 32'h11111111, 32'h80,    1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h12345678, 0, 0, 32'h11111111, 32'h80, 1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         1, 7, 32'h12345678, 32'h0,     1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         0, 7, 32'h12345678, 32'h0,     1, 0));
      // fill the queue with rd=1..4, extra issue ignored
      tbl.push_back(mk(0, 0, 0,            1, 1, 0, 0,         0, 7, 32'h12345678, 32'h2,     1, 0));
      tbl.push_back(mk(0, 0, 0,            1, 2, 0, 0,         0, 7, 32'h12345678, 32'h6,     1, 0));
      tbl.push_back(mk(0, 0, 0,            1, 3, 0, 0,         0, 7, 32'h12345678, 32'hE,     1, 0));
      tbl.push_back(mk(0, 0, 0,            1, 4, 0, 0,         0, 7, 32'h12345678, 32'h1E,    0, 0));
      tbl.push_back(mk(0, 0, 0,            1, 5, 0, 0,         0, 7, 32'h12345678, 32'h1E,    0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'hA,     0, 7, 32'h12345678, 32'h1E,    0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'hB,     1, 1, 32'hA,        32'h1C,    1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'hC,     1, 2, 32'hB,        32'h18,    1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'hD,     1, 3, 32'hC,        32'h10,    1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         1, 4, 32'hD,        32'h0,     1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         0, 4, 32'hD,        32'h0,     1, 0));
      // load rd=9 starved by three ALU writes
      tbl.push_back(mk(0, 0, 0,            1, 9, 0, 0,         0, 4, 32'hD,        32'h200,   1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h99,    0, 4, 32'hD,        32'h200,   1, 0));
      tbl.push_back(mk(1, 10, 32'h10,      0, 0, 0, 0,         1, 10, 32'h10,      32'h200,   1, 0));
      tbl.push_back(mk(1, 11, 32'h11,      0, 0, 0, 0,         1, 11, 32'h11,      32'h200,   1, 0));
      tbl.push_back(mk(1, 12, 32'h12,      0, 0, 0, 0,         1, 12, 32'h12,      32'h200,   1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         1, 9, 32'h99,       32'h0,     1, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         0, 9, 32'h99,       32'h0,     1, 0));
      // stray responses
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h55,    0, 9, 32'h99,       32'h0,     1, 1));
      tbl.push_back(mk(0, 0, 0,            1, 8, 1, 32'h66,    0, 9, 32'h99,       32'h100,   1, 1));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         0, 9, 32'h99,       32'h100,   1, 1));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 32'h88,    0, 9, 32'h99,       32'h100,   1, 1));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,         1, 8, 32'h88,       32'h0,     1, 1));

      foreach (tbl[i]) begin
         step(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].li, tbl[i].lrd, tbl[i].rv, tbl[i].rdat);
         chk($sformatf("t%0d_reg_write", i), {31'd0, reg_write}, {31'd0, tbl[i].e_we});
         chk($sformatf("t%0d_rd", i), {27'd0, rd}, {27'd0, tbl[i].e_rd});
         chk($sformatf("t%0d_write_data", i), write_data, tbl[i].e_wd);
         chk($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("t%0d_ready", i), {31'd0, ld_issue_ready}, {31'd0, tbl[i].e_rdy});
         chk($sformatf("t%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, tbl[i].e_err});
      end

      // Reset with two loads pending: outputs clear at once, late response errors.
      step(0, 0, 0, 1, 5'd3, 0, 0);
      step(0, 0, 0, 1, 5'd6, 0, 0);
      chk("pre_rst_busy", busy, 32'h48);
      #2 resetn = 1'b0;
      #1 chk_reset_vals();
      model_reset();
      #2 resetn = 1'b1;
      step(0, 0, 0, 0, 0, 1, 32'h77);
      chk("late_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("late_rsp_nowrite", {31'd0, reg_write}, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("late_rsp_nowrite2", {31'd0, reg_write}, 32'd0);

      // Random traffic against the model, starting from a clean reset.
      resetn = 1'b0;
      #2 resetn = 1'b1;
      model_reset();
      for (int n = 0; n < 400; n++) begin
         logic av, li, rv;
         av = ($urandom_range(0, 2) == 0);
         li = ($urandom_range(0, 1) == 0);
         if (m_dat.size() < m_rd.size()) rv = ($urandom_range(0, 1) == 0);
         else rv = ($urandom_range(0, 39) == 0);
         step(av, 5'($urandom_range(0, 31)), $urandom, li, 5'($urandom_range(0, 31)),
              rv, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
